// File: rtl/fox_node_message_interface.sv
// -----------------------------------------------------------------------------
// fox_node_message_interface
//
// Network-side endpoint of one Fox/Hoplite multicast processing node.
//
// TX path: per-field staging registers are written by the node's memory-mapped
// IO strobes. On packet_complete_in the packet is assembled from the staging
// registers (a field written in the same cycle wins) and queued. The queue
// drains to the router over a valid/ready handshake.
//
// RX path: packets from the router land in a head register (or in the storage
// FIFO behind it when the head is occupied). The head's fields are presented
// as stable levels and popped with a one-cycle message_in_read strobe. On a pop
// the head refills from storage at the same edge, so there is no bubble.
//
// Ports
//   clk, reset_n                  clock, synchronous active-low reset
//   *_in / *_in_valid             field writes into the staging registers
//   packet_complete_in            enqueue the assembled packet
//   message_out_ready             TX queue has room
//   tx_overflow                   sticky: a packet was dropped on a full queue
//   packet_out/_valid/_ready      TX handshake towards the router
//   packet_in/_valid/_ready       RX handshake from the router
//   msg_*                         fields of the RX head packet
//   message_in_valid              head register holds a packet
//   message_in_available          head valid or storage non-empty
//   message_in_read               pop the head packet
//
// Packet layout, MSB to LSB:
//   x, y, multicast_group, done, result, matrix_type, matrix_x, matrix_y, element
// -----------------------------------------------------------------------------
module fox_node_message_interface #(
    parameter int COORD_BITS          = 1,
    parameter int MULTICAST_GROUP_BITS = 1,
    parameter int MATRIX_TYPE_BITS    = 1,
    parameter int MATRIX_COORD_BITS   = 8,
    parameter int MATRIX_ELEMENT_BITS = 32,
    parameter int TX_FIFO_DEPTH       = 4,
    parameter int RX_FIFO_DEPTH       = 8,
    localparam int PACKET_BITS = 2*COORD_BITS + MULTICAST_GROUP_BITS + 2 +
                                 MATRIX_TYPE_BITS + 2*MATRIX_COORD_BITS +
                                 MATRIX_ELEMENT_BITS
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [COORD_BITS-1:0]           x_coord_in,
    input  logic                            x_coord_in_valid,
    input  logic [COORD_BITS-1:0]           y_coord_in,
    input  logic                            y_coord_in_valid,
    input  logic [MULTICAST_GROUP_BITS-1:0] multicast_group_in,
    input  logic                            multicast_group_in_valid,
    input  logic                            done_flag_in,
    input  logic                            done_flag_in_valid,
    input  logic                            result_flag_in,
    input  logic                            result_flag_in_valid,
    input  logic [MATRIX_TYPE_BITS-1:0]     matrix_type_in,
    input  logic                            matrix_type_in_valid,
    input  logic [MATRIX_COORD_BITS-1:0]    matrix_x_coord_in,
    input  logic                            matrix_x_coord_in_valid,
    input  logic [MATRIX_COORD_BITS-1:0]    matrix_y_coord_in,
    input  logic                            matrix_y_coord_in_valid,
    input  logic [MATRIX_ELEMENT_BITS-1:0]  matrix_element_in,
    input  logic                            matrix_element_in_valid,
    input  logic                            packet_complete_in,
    output logic                            message_out_ready,
    output logic                            tx_overflow,
    output logic [PACKET_BITS-1:0]          packet_out,
    output logic                            packet_out_valid,
    input  logic                            packet_out_ready,
    input  logic [PACKET_BITS-1:0]          packet_in,
    input  logic                            packet_in_valid,
    output logic                            packet_in_ready,
    output logic [MULTICAST_GROUP_BITS-1:0] msg_multicast_group,
    output logic                            msg_done_flag,
    output logic                            msg_result_flag,
    output logic [MATRIX_TYPE_BITS-1:0]     msg_matrix_type,
    output logic [MATRIX_COORD_BITS-1:0]    msg_matrix_x_coord,
    output logic [MATRIX_COORD_BITS-1:0]    msg_matrix_y_coord,
    output logic [MATRIX_ELEMENT_BITS-1:0]  msg_matrix_element,
    output logic                            message_in_valid,
    output logic                            message_in_available,
    input  logic                            message_in_read
);

    localparam int TX_PTR_W = $clog2(TX_FIFO_DEPTH);
    localparam int TX_CNT_W = TX_PTR_W + 1;
    localparam int RX_PTR_W = $clog2(RX_FIFO_DEPTH);
    localparam int RX_CNT_W = RX_PTR_W + 1;
    localparam logic [TX_CNT_W-1:0] TX_FULL = TX_CNT_W'(TX_FIFO_DEPTH);
    localparam logic [RX_CNT_W-1:0] RX_FULL = RX_CNT_W'(RX_FIFO_DEPTH);

    // Field positions inside a packet
    localparam int ELEM_LSB   = 0;
    localparam int MY_LSB     = ELEM_LSB + MATRIX_ELEMENT_BITS;
    localparam int MX_LSB     = MY_LSB + MATRIX_COORD_BITS;
    localparam int TYPE_LSB   = MX_LSB + MATRIX_COORD_BITS;
    localparam int RESULT_LSB = TYPE_LSB + MATRIX_TYPE_BITS;
    localparam int DONE_LSB   = RESULT_LSB + 1;
    localparam int GROUP_LSB  = DONE_LSB + 1;
    localparam int COORD_LSB  = GROUP_LSB + MULTICAST_GROUP_BITS;

    // Staging registers
    logic [COORD_BITS-1:0]           x_q, x_d, y_q, y_d;
    logic [MULTICAST_GROUP_BITS-1:0] group_q, group_d;
    logic                            done_q, done_d, result_q, result_d;
    logic [MATRIX_TYPE_BITS-1:0]     type_q, type_d;
    logic [MATRIX_COORD_BITS-1:0]    mx_q, mx_d, my_q, my_d;
    logic [MATRIX_ELEMENT_BITS-1:0]  elem_q, elem_d;
    logic [PACKET_BITS-1:0]          tx_packet_s;

    // TX queue
    logic [PACKET_BITS-1:0] tx_mem_q [TX_FIFO_DEPTH];
    logic [TX_PTR_W-1:0]    tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [TX_CNT_W-1:0]    tx_count_q, tx_count_d;
    logic                   tx_overflow_q, tx_overflow_d;
    logic                   tx_room_s, tx_push_s, tx_pop_s;

    // RX head register and storage
    logic [PACKET_BITS-1:0] rx_mem_q [RX_FIFO_DEPTH];
    logic [PACKET_BITS-1:0] head_q, head_d;
    logic                   head_valid_q, head_valid_d;
    logic [RX_PTR_W-1:0]    rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [RX_CNT_W-1:0]    rx_count_q, rx_count_d;
    logic                   rx_store_empty_s, rx_pop_s, rx_acc_s;
    logic                   rx_bypass_s, rx_wr_s, rx_rd_s;
    logic                   head_coord_unused_s;

    // Write-first view of every field; also the staging next state
    always_comb begin
        x_d      = x_coord_in_valid        ? x_coord_in         : x_q;
        y_d      = y_coord_in_valid        ? y_coord_in         : y_q;
        group_d  = multicast_group_in_valid ? multicast_group_in : group_q;
        done_d   = done_flag_in_valid      ? done_flag_in       : done_q;
        result_d = result_flag_in_valid    ? result_flag_in     : result_q;
        type_d   = matrix_type_in_valid    ? matrix_type_in     : type_q;
        mx_d     = matrix_x_coord_in_valid ? matrix_x_coord_in  : mx_q;
        my_d     = matrix_y_coord_in_valid ? matrix_y_coord_in  : my_q;
        elem_d   = matrix_element_in_valid ? matrix_element_in  : elem_q;
        tx_packet_s = {x_d, y_d, group_d, done_d, result_d, type_d, mx_d, my_d, elem_d};
    end

    // TX queue control: a full queue rejects a push even when popping
    always_comb begin
        tx_room_s     = (tx_count_q < TX_FULL);
        tx_push_s     = packet_complete_in & tx_room_s;
        tx_pop_s      = (tx_count_q != {TX_CNT_W{1'b0}}) & packet_out_ready;
        tx_wr_ptr_d   = tx_push_s ? (tx_wr_ptr_q + TX_PTR_W'(1)) : tx_wr_ptr_q;
        tx_rd_ptr_d   = tx_pop_s  ? (tx_rd_ptr_q + TX_PTR_W'(1)) : tx_rd_ptr_q;
        tx_overflow_d = tx_overflow_q | (packet_complete_in & ~tx_room_s);
        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_count_d = tx_count_q + TX_CNT_W'(1);
            2'b01:   tx_count_d = tx_count_q - TX_CNT_W'(1);
            default: tx_count_d = tx_count_q;
        endcase
    end

    // RX control: bypass into the head when it is (or is becoming) free and
    // storage is empty; otherwise queue behind it. An invalid head with
    // non-empty storage also refills, so the head can never strand data.
    always_comb begin
        rx_store_empty_s = (rx_count_q == {RX_CNT_W{1'b0}});
        rx_pop_s    = message_in_read & head_valid_q;
        rx_acc_s    = packet_in_valid & (rx_count_q < RX_FULL);
        rx_bypass_s = rx_acc_s & rx_store_empty_s & (~head_valid_q | rx_pop_s);
        rx_wr_s     = rx_acc_s & ~rx_bypass_s;
        rx_rd_s     = (rx_pop_s | ~head_valid_q) & ~rx_store_empty_s;
        rx_wr_ptr_d = rx_wr_s ? (rx_wr_ptr_q + RX_PTR_W'(1)) : rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_s ? (rx_rd_ptr_q + RX_PTR_W'(1)) : rx_rd_ptr_q;
        if (rx_rd_s) begin
            head_d       = rx_mem_q[rx_rd_ptr_q];
            head_valid_d = 1'b1;
        end else if (rx_bypass_s) begin
            head_d       = packet_in;
            head_valid_d = 1'b1;
        end else if (rx_pop_s) begin
            head_d       = head_q;
            head_valid_d = 1'b0;
        end else begin
            head_d       = head_q;
            head_valid_d = head_valid_q;
        end
        case ({rx_wr_s, rx_rd_s})
            2'b10:   rx_count_d = rx_count_q + RX_CNT_W'(1);
            2'b01:   rx_count_d = rx_count_q - RX_CNT_W'(1);
            default: rx_count_d = rx_count_q;
        endcase
    end

    // State registers with synchronous reset; queued data is dropped by
    // clearing pointers and counts
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x_q           <= {COORD_BITS{1'b0}};
            y_q           <= {COORD_BITS{1'b0}};
            group_q       <= {MULTICAST_GROUP_BITS{1'b0}};
            done_q        <= 1'b0;
            result_q      <= 1'b0;
            type_q        <= {MATRIX_TYPE_BITS{1'b0}};
            mx_q          <= {MATRIX_COORD_BITS{1'b0}};
            my_q          <= {MATRIX_COORD_BITS{1'b0}};
            elem_q        <= {MATRIX_ELEMENT_BITS{1'b0}};
            tx_wr_ptr_q   <= {TX_PTR_W{1'b0}};
            tx_rd_ptr_q   <= {TX_PTR_W{1'b0}};
            tx_count_q    <= {TX_CNT_W{1'b0}};
            tx_overflow_q <= 1'b0;
            head_q        <= {PACKET_BITS{1'b0}};
            head_valid_q  <= 1'b0;
            rx_wr_ptr_q   <= {RX_PTR_W{1'b0}};
            rx_rd_ptr_q   <= {RX_PTR_W{1'b0}};
            rx_count_q    <= {RX_CNT_W{1'b0}};
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            group_q       <= group_d;
            done_q        <= done_d;
            result_q      <= result_d;
            type_q        <= type_d;
            mx_q          <= mx_d;
            my_q          <= my_d;
            elem_q        <= elem_d;
            tx_wr_ptr_q   <= tx_wr_ptr_d;
            tx_rd_ptr_q   <= tx_rd_ptr_d;
            tx_count_q    <= tx_count_d;
            tx_overflow_q <= tx_overflow_d;
            head_q        <= head_d;
            head_valid_q  <= head_valid_d;
            rx_wr_ptr_q   <= rx_wr_ptr_d;
            rx_rd_ptr_q   <= rx_rd_ptr_d;
            rx_count_q    <= rx_count_d;
        end
    end

    // Queue storage arrays; validity is tracked by pointers and counts only
    always_ff @(posedge clk) begin
        if (tx_push_s) begin
            tx_mem_q[tx_wr_ptr_q] <= tx_packet_s;
        end
        if (rx_wr_s) begin
            rx_mem_q[rx_wr_ptr_q] <= packet_in;
        end
    end

    // Outputs are driven straight from registered state
    assign message_out_ready    = tx_count_q < TX_FULL;
    assign tx_overflow          = tx_overflow_q;
    assign packet_out           = tx_mem_q[tx_rd_ptr_q];
    assign packet_out_valid     = tx_count_q != {TX_CNT_W{1'b0}};
    assign packet_in_ready      = rx_count_q < RX_FULL;
    assign message_in_valid     = head_valid_q;
    assign message_in_available = head_valid_q | ~rx_store_empty_s;

    assign msg_matrix_element  = head_q[ELEM_LSB +: MATRIX_ELEMENT_BITS];
    assign msg_matrix_y_coord  = head_q[MY_LSB +: MATRIX_COORD_BITS];
    assign msg_matrix_x_coord  = head_q[MX_LSB +: MATRIX_COORD_BITS];
    assign msg_matrix_type     = head_q[TYPE_LSB +: MATRIX_TYPE_BITS];
    assign msg_result_flag     = head_q[RESULT_LSB];
    assign msg_done_flag       = head_q[DONE_LSB];
    assign msg_multicast_group = head_q[GROUP_LSB +: MULTICAST_GROUP_BITS];

    // Destination coordinates are meaningless once a packet has arrived here
    assign head_coord_unused_s = ^head_q[COORD_LSB +: 2*COORD_BITS];

endmodule

// File: tb/tb_fox_node_message_interface.sv
`timescale 1ns/1ps
module tb_fox_node_message_interface;
    localparam int CB  = 1;
    localparam int GB  = 1;
    localparam int MT  = 1;
    localparam int MC  = 8;
    localparam int EB  = 32;
    localparam int TXD = 4;
    localparam int RXD = 8;
    localparam int PB  = 2*CB + GB + 2 + MT + 2*MC + EB;
    localparam int LB  = PB - 2*CB;   // fields visible to the receiving node

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [CB-1:0] x_coord_in, y_coord_in;
    logic x_coord_in_valid, y_coord_in_valid;
    logic [GB-1:0] multicast_group_in;
    logic multicast_group_in_valid;
    logic done_flag_in, done_flag_in_valid, result_flag_in, result_flag_in_valid;
    logic [MT-1:0] matrix_type_in;
    logic matrix_type_in_valid;
    logic [MC-1:0] matrix_x_coord_in, matrix_y_coord_in;
    logic matrix_x_coord_in_valid, matrix_y_coord_in_valid;
    logic [EB-1:0] matrix_element_in;
    logic matrix_element_in_valid;
    logic packet_complete_in, message_out_ready, tx_overflow;
    logic [PB-1:0] packet_out, packet_in;
    logic packet_out_valid, packet_out_ready, packet_in_valid, packet_in_ready;
    logic [GB-1:0] msg_multicast_group;
    logic msg_done_flag, msg_result_flag;
    logic [MT-1:0] msg_matrix_type;
    logic [MC-1:0] msg_matrix_x_coord, msg_matrix_y_coord;
    logic [EB-1:0] msg_matrix_element;
    logic message_in_valid, message_in_available, message_in_read;

    always #5 clk = ~clk;

    fox_node_message_interface dut (
        .clk(clk), .reset_n(reset_n),
        .x_coord_in(x_coord_in), .x_coord_in_valid(x_coord_in_valid),
        .y_coord_in(y_coord_in), .y_coord_in_valid(y_coord_in_valid),
        .multicast_group_in(multicast_group_in), .multicast_group_in_valid(multicast_group_in_valid),
        .done_flag_in(done_flag_in), .done_flag_in_valid(done_flag_in_valid),
        .result_flag_in(result_flag_in), .result_flag_in_valid(result_flag_in_valid),
        .matrix_type_in(matrix_type_in), .matrix_type_in_valid(matrix_type_in_valid),
        .matrix_x_coord_in(matrix_x_coord_in), .matrix_x_coord_in_valid(matrix_x_coord_in_valid),
        .matrix_y_coord_in(matrix_y_coord_in), .matrix_y_coord_in_valid(matrix_y_coord_in_valid),
        .matrix_element_in(matrix_element_in), .matrix_element_in_valid(matrix_element_in_valid),
        .packet_complete_in(packet_complete_in), .message_out_ready(message_out_ready),
        .tx_overflow(tx_overflow), .packet_out(packet_out), .packet_out_valid(packet_out_valid),
        .packet_out_ready(packet_out_ready), .packet_in(packet_in), .packet_in_valid(packet_in_valid),
        .packet_in_ready(packet_in_ready), .msg_multicast_group(msg_multicast_group),
        .msg_done_flag(msg_done_flag), .msg_result_flag(msg_result_flag),
        .msg_matrix_type(msg_matrix_type), .msg_matrix_x_coord(msg_matrix_x_coord),
        .msg_matrix_y_coord(msg_matrix_y_coord), .msg_matrix_element(msg_matrix_element),
        .message_in_valid(message_in_valid), .message_in_available(message_in_available),
        .message_in_read(message_in_read)
    );

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    // Reference model: TX queue contents, everything held at the node on the
    // RX side (head first), sticky overflow and the field staging values.
    logic [PB-1:0] tx_q [$];
    logic [PB-1:0] rx_q [$];
    bit m_ovf = 1'b0;
    logic [CB-1:0] s_x = '0, s_y = '0;
    logic [GB-1:0] s_g = '0;
    logic s_d = 1'b0, s_r = 1'b0;
    logic [MT-1:0] s_t = '0;
    logic [MC-1:0] s_mx = '0, s_my = '0;
    logic [EB-1:0] s_e = '0;
    logic [PB-1:0] m_pkt, m_head;
    bit m_can_push, m_tx_pop, m_rx_pop, m_rx_acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update and monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (started) begin
            chk("tx_valid", packet_out_valid, tx_q.size() != 0);
            chk("tx_room", message_out_ready, tx_q.size() < TXD);
            chk("tx_ovf", tx_overflow, m_ovf);
            chk("rx_ready", packet_in_ready, rx_q.size() < RXD + 1);
            chk("rx_valid", message_in_valid, rx_q.size() != 0);
            chk("rx_avail", message_in_available, rx_q.size() != 0);
            if (!reset_n) begin
                tx_q.delete();
                rx_q.delete();
                m_ovf = 1'b0;
                s_x = '0; s_y = '0; s_g = '0; s_d = 1'b0; s_r = 1'b0;
                s_t = '0; s_mx = '0; s_my = '0; s_e = '0;
            end else begin
                m_can_push = tx_q.size() < TXD;
                m_tx_pop = (tx_q.size() != 0) && packet_out_ready;
                if (m_tx_pop) begin
                    chk("tx_pkt", packet_out, tx_q[0]);
                    void'(tx_q.pop_front());
                end
                if (x_coord_in_valid)        s_x  = x_coord_in;
                if (y_coord_in_valid)        s_y  = y_coord_in;
                if (multicast_group_in_valid) s_g = multicast_group_in;
                if (done_flag_in_valid)      s_d  = done_flag_in;
                if (result_flag_in_valid)    s_r  = result_flag_in;
                if (matrix_type_in_valid)    s_t  = matrix_type_in;
                if (matrix_x_coord_in_valid) s_mx = matrix_x_coord_in;
                if (matrix_y_coord_in_valid) s_my = matrix_y_coord_in;
                if (matrix_element_in_valid) s_e  = matrix_element_in;
                m_pkt = {s_x, s_y, s_g, s_d, s_r, s_t, s_mx, s_my, s_e};
                if (packet_complete_in) begin
                    if (m_can_push) tx_q.push_back(m_pkt);
                    else m_ovf = 1'b1;
                end
                m_rx_pop = message_in_read && (rx_q.size() != 0);
                m_rx_acc = packet_in_valid && (rx_q.size() < RXD + 1);
                if (m_rx_pop) begin
                    m_head = rx_q[0];
                    chk("rx_head", {msg_multicast_group, msg_done_flag, msg_result_flag,
                                    msg_matrix_type, msg_matrix_x_coord, msg_matrix_y_coord,
                                    msg_matrix_element}, m_head[LB-1:0]);
                    void'(rx_q.pop_front());
                end
                if (m_rx_acc) rx_q.push_back(packet_in);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        x_coord_in_valid = 1'b0; y_coord_in_valid = 1'b0; multicast_group_in_valid = 1'b0;
        done_flag_in_valid = 1'b0; result_flag_in_valid = 1'b0; matrix_type_in_valid = 1'b0;
        matrix_x_coord_in_valid = 1'b0; matrix_y_coord_in_valid = 1'b0;
        matrix_element_in_valid = 1'b0; packet_complete_in = 1'b0;
        packet_in_valid = 1'b0; message_in_read = 1'b0;
    endtask

    task automatic write_all(input logic [CB-1:0] x, input logic [CB-1:0] y, input logic [GB-1:0] g,
                             input logic d, input logic r, input logic [MT-1:0] t,
                             input logic [MC-1:0] mx, input logic [MC-1:0] my, input logic [EB-1:0] e);
        x_coord_in = x; y_coord_in = y; multicast_group_in = g; done_flag_in = d;
        result_flag_in = r; matrix_type_in = t; matrix_x_coord_in = mx;
        matrix_y_coord_in = my; matrix_element_in = e;
        x_coord_in_valid = 1'b1; y_coord_in_valid = 1'b1; multicast_group_in_valid = 1'b1;
        done_flag_in_valid = 1'b1; result_flag_in_valid = 1'b1; matrix_type_in_valid = 1'b1;
        matrix_x_coord_in_valid = 1'b1; matrix_y_coord_in_valid = 1'b1; matrix_element_in_valid = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic drain_tx();
        packet_out_ready = 1'b1;
        for (int i = 0; i < 40 && packet_out_valid; i++) tick();
        chk("tx_drain_done", packet_out_valid, 1'b0);
    endtask

    initial begin
        logic [PB-1:0] p;
        idle_inputs();
        write_all('0, '0, '0, 1'b0, 1'b0, '0, '0, '0, '0);   // values only; reset is held
        packet_out_ready = 1'b1;
        packet_in = '0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        started = 1'b1;
        chk("rst_tx_valid", packet_out_valid, 1'b0);
        chk("rst_rx_valid", message_in_valid, 1'b0);
        chk("rst_out_ready", message_out_ready, 1'b1);
        chk("rst_in_ready", packet_in_ready, 1'b1);
        chk("rst_ovf", tx_overflow, 1'b0);
        reset_n = 1'b1;
        tick();

        // Single packet assembly and emission
        write_all(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 8'h0A, 32'hDEADBEEF);
        packet_complete_in = 1'b1;
        tick();
        packet_complete_in = 1'b0;
        chk("t1_valid", packet_out_valid, 1'b1);
        chk("t1_pkt", packet_out, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 8'h0A, 32'hDEADBEEF});
        tick();
        chk("t1_valid_drop", packet_out_valid, 1'b0);

        // Overflow: five completes into a stalled four-entry queue
        packet_out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            matrix_element_in = EB'(i);
            matrix_element_in_valid = 1'b1;
            packet_complete_in = 1'b1;
            tick();
            if (i == 4) chk("t2_full", message_out_ready, 1'b0);
        end
        idle_inputs();
        chk("t2_ovf", tx_overflow, 1'b1);
        chk("t2_head_elem", packet_out[EB-1:0], 32'd1);
        drain_tx();

        // Write-first bypass, then fields persist into the next packet
        packet_out_ready = 1'b0;
        matrix_element_in = 32'h77;
        matrix_element_in_valid = 1'b1;
        packet_complete_in = 1'b1;
        tick();
        matrix_element_in_valid = 1'b0;
        tick();
        packet_complete_in = 1'b0;
        chk("t3_bypass_elem", packet_out[EB-1:0], 32'h77);
        packet_out_ready = 1'b1;
        tick();
        chk("t3_repeat_elem", packet_out[EB-1:0], 32'h77);
        drain_tx();

        // Ten back-to-back router packets, no reads: head plus eight stored
        for (int i = 0; i < 10; i++) begin
            p = {(PB-EB)'($urandom), EB'(i + 1)};
            packet_in = p;
            packet_in_valid = 1'b1;
            tick();
        end
        packet_in_valid = 1'b0;
        chk("t4_in_full", packet_in_ready, 1'b0);
        message_in_read = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk("t4_valid_across_pop", message_in_valid, 1'b1);
            chk("t4_elem_order", msg_matrix_element, EB'(i + 1));
            tick();
        end
        message_in_read = 1'b0;
        chk("t4_empty_valid", message_in_valid, 1'b0);
        chk("t4_empty_avail", message_in_available, 1'b0);

        // Read with empty head is ignored; then pop and accept together
        message_in_read = 1'b1;
        tick();
        message_in_read = 1'b0;
        chk("t5_ignored_read", message_in_valid, 1'b0);
        packet_in = {(PB-EB)'($urandom), 32'hA1};
        packet_in_valid = 1'b1;
        tick();
        packet_in = {(PB-EB)'($urandom), 32'hB2};
        message_in_read = 1'b1;
        tick();
        packet_in_valid = 1'b0;
        message_in_read = 1'b0;
        chk("t5_pop_accept_valid", message_in_valid, 1'b1);
        chk("t5_pop_accept_elem", msg_matrix_element, 32'hB2);
        message_in_read = 1'b1;
        tick();
        message_in_read = 1'b0;

        // Reset with traffic queued in both directions
        packet_out_ready = 1'b0;
        packet_complete_in = 1'b1;
        repeat (3) tick();
        packet_complete_in = 1'b0;
        packet_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            packet_in = {(PB-EB)'($urandom), EB'($urandom)};
            tick();
        end
        packet_in_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("t6_tx_valid", packet_out_valid, 1'b0);
        chk("t6_rx_valid", message_in_valid, 1'b0);
        chk("t6_ovf", tx_overflow, 1'b0);
        chk("t6_out_ready", message_out_ready, 1'b1);
        chk("t6_in_ready", packet_in_ready, 1'b1);
        chk("t6_avail", message_in_available, 1'b0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            x_coord_in = CB'($urandom);          x_coord_in_valid = ($urandom_range(3, 0) == 0);
            y_coord_in = CB'($urandom);          y_coord_in_valid = ($urandom_range(3, 0) == 0);
            multicast_group_in = GB'($urandom);  multicast_group_in_valid = ($urandom_range(3, 0) == 0);
            done_flag_in = 1'($urandom);         done_flag_in_valid = ($urandom_range(3, 0) == 0);
            result_flag_in = 1'($urandom);       result_flag_in_valid = ($urandom_range(3, 0) == 0);
            matrix_type_in = MT'($urandom);      matrix_type_in_valid = ($urandom_range(3, 0) == 0);
            matrix_x_coord_in = MC'($urandom);   matrix_x_coord_in_valid = ($urandom_range(3, 0) == 0);
            matrix_y_coord_in = MC'($urandom);   matrix_y_coord_in_valid = ($urandom_range(3, 0) == 0);
            matrix_element_in = EB'($urandom);   matrix_element_in_valid = ($urandom_range(3, 0) == 0);
            packet_complete_in = ($urandom_range(2, 0) == 0);
            packet_out_ready = ($urandom_range(1, 0) == 0);
            packet_in = {(PB-EB)'($urandom), EB'($urandom)};
            packet_in_valid = ($urandom_range(1, 0) == 0);
            message_in_read = ($urandom_range(2, 0) == 0);
            tick();
        end
        idle_inputs();
        drain_tx();
        message_in_read = 1'b1;
        for (int i = 0; i < 20 && message_in_available; i++) tick();
        message_in_read = 1'b0;
        chk("rx_drain_done", message_in_available, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
